// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial 4-bit subtractor with borrow-in. Resolves one bit per clock,
//   LSB first, through a single full-subtractor cell and a borrow flip-flop.
//   Uses a start/busy/done handshake that matches the ripple-carry adder.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       request a subtraction (honoured only in IDLE)
//   a, b        minuend / subtrahend, captured on the accepted start
//   b_in        borrow-in, captured on the accepted start
//   diff        (a - b - b_in) mod 16, updated on completion only
//   borrow_out  unsigned borrow (a < b + b_in)
//   overflow    signed two's-complement overflow
//   busy        high while bits are being resolved
//   done        one-cycle completion pulse; results valid from this cycle
module serial_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       b_in,
    output logic [3:0] diff,
    output logic       borrow_out,
    output logic       overflow,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] a_sh;
    logic [3:0] b_sh;
    logic [3:0] res;
    logic [1:0] cnt;
    logic       br;

    // Full-subtractor cell on the current LSBs of the operand registers
    logic a_i;
    logic b_i;
    logic d_i;
    logic br_next;

    always_comb begin
        a_i     = a_sh[0];
        b_i     = b_sh[0];
        d_i     = a_i ^ b_i ^ br;
        br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= b_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    res  <= {d_i, res[3:1]};
                    a_sh <= {1'b0, a_sh[3:1]};
                    b_sh <= {1'b0, b_sh[3:1]};
                    br   <= br_next;
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // On the last bit a_i/b_i are the captured sign bits
                        // and d_i is the result sign bit.
                        diff       <= {d_i, res[3:1]};
                        borrow_out <= br_next;
                        overflow   <= (a_i ^ b_i) & (d_i ^ a_i);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed-vector bench for serial_subtractor with hand-computed results.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       b_in;
    logic [3:0] diff;
    logic       borrow_out;
    logic       overflow;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    serial_subtractor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .b_in       (b_in),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one subtraction and check handshake timing and results.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                          input logic [3:0] ediff, input logic eb, input logic eov);
        @(negedge clk);
        a = ta; b = tb_v; b_in = tbin; start = 1'b1;
        @(posedge clk); #1;            // E0
        start = 1'b0;
        a = ~ta; b = ~tb_v; b_in = ~tbin;   // operands must already be captured
        chk("busy_e0", {7'd0, busy}, 8'd1);
        chk("done_e0", {7'd0, done}, 8'd0);
        for (int unsigned k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            chk("busy_mid", {7'd0, busy}, 8'd1);
            chk("done_mid", {7'd0, done}, 8'd0);
        end
        @(posedge clk); #1;            // E4
        chk("done_e4", {7'd0, done}, 8'd1);
        chk("busy_e4", {7'd0, busy}, 8'd0);
        chk("diff", {4'd0, diff}, {4'd0, ediff});
        chk("borrow_out", {7'd0, borrow_out}, {7'd0, eb});
        chk("overflow", {7'd0, overflow}, {7'd0, eov});
        @(posedge clk); #1;            // E5
        chk("done_e5", {7'd0, done}, 8'd0);
        chk("diff_hold", {4'd0, diff}, {4'd0, ediff});
    endtask

    int dones;
    logic [3:0] seen_diff;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        #3;
        chk("rst_diff", {4'd0, diff}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_bo", {7'd0, borrow_out}, 8'd0);
        chk("rst_ov", {7'd0, overflow}, 8'd0);
        @(negedge clk); rst = 1'b0;

        run_op(4'd5, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0);
        run_op(4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0);
        run_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
        run_op(4'd7, 4'd15, 1'b0, 4'd8, 1'b1, 1'b1);
        run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0);
        run_op(4'hA, 4'd3, 1'b1, 4'd6, 1'b0, 1'b1);

        // Start during busy must be ignored
        @(negedge clk);
        a = 4'd9; b = 4'd2; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        dones = 0; seen_diff = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                seen_diff = diff;
            end
        end
        chk("busy_start_dones", dones[7:0], 8'd1);
        chk("busy_start_diff", {4'd0, seen_diff}, 8'd7);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a = 4'd6; b = 4'd1; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;   // E0
        @(posedge clk); #2;                 // second busy cycle, between edges
        rst = 1'b1;
        #1;
        chk("arst_diff", {4'd0, diff}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        chk("arst_bo", {7'd0, borrow_out}, 8'd0);
        chk("arst_ov", {7'd0, overflow}, 8'd0);
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int unsigned k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("arst_no_done", dones[7:0], 8'd0);

        run_op(4'd4, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Multi-cycle, bit-serial 4-bit subtractor with borrow-in: the inverse operation of the team's 4-bit ripple-carry adder.
- Resolves one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake, so a controller can issue subtractions to it in the same way it issues additions to the adder.
- Reports the unsigned borrow-out and the signed two's-complement overflow.

## Interface

Parameters:
- none; width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a subtraction; sampled on the rising edge, honoured only in IDLE.
- a  input  4  minuend; captured on the accepted start.
- b  input  4  subtrahend; captured on the accepted start.
- b_in  input  1  borrow-in; captured on the accepted start.
- diff  output  4  result, (a - b - b_in) mod 16.
- borrow_out  output  1  1 when a < b + b_in (unsigned).
- overflow  output  1  signed overflow: a[3] != b[3] and diff[3] != a[3].
- busy  output  1  high while bits are being resolved.
- done  output  1  single-cycle pulse; diff, borrow_out and overflow are valid from this cycle.

## Operation

States are IDLE, SHIFT and DONE.

IDLE:
- On start=1, capture a, b and b_in into operand shift registers.
- Load the borrow flip-flop with b_in.
- Clear the 2-bit bit counter to 0 and go to SHIFT.
- With start=0, remain in IDLE.

SHIFT:
- Each edge resolves bit i = counter.
- d_i = a_i ^ b_i ^ br.
- br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
- d_i shifts into an internal result register (MSB side); the operand registers shift right; the counter increments.
- On the edge that resolves bit 3, the following happen together:
  - diff <= full internal result.
  - borrow_out <= br_next.
  - overflow <= (a[3] ^ b[3]) & (diff[3] ^ a[3]), using the captured operands.
  - Go to DONE.

DONE:
- done=1 for exactly one cycle, then IDLE on the next edge.

Start handling:
- start is ignored in SHIFT and DONE.
- Operand inputs may change freely after capture without affecting the result.

Output holding:
- diff, borrow_out and overflow update only on the SHIFT→DONE edge.
- They then hold until the next completion or reset.
- They are never visible in a partially resolved form.

Reset:
- rst=1 forces IDLE immediately and asynchronously, regardless of clk.
- diff=0, borrow_out=0, overflow=0, busy=0, done=0; counter, borrow flip-flop and internal registers clear.
- Reset mid-SHIFT aborts the operation; no done is produced.
- The first start after rst deasserts is accepted normally.

## Timing

- Accepted start at edge E0.
- busy=1 in the cycles following E0, E1, E2 and E3.
- Bits 0..3 are resolved at E1..E4.
- After E4: busy=0, done=1, and the results are valid.
- After E5: done=0, state is IDLE; a start sampled at E5 is accepted.
- Latency is 4 cycles from the accepted start to done; minimum issue interval is 5 cycles.
- busy and done are never high together.
- Outputs are driven directly from registers, with no combinational path from inputs to outputs.

## Test plan

- Start with a=5, b=3, b_in=0.
  - Expected: done exactly 4 cycles after the start edge; diff=2, borrow_out=0, overflow=0.
  - busy high for 4 cycles and low when done rises.
- Start with a=3, b=5, b_in=0.
  - Expected: diff=4'hE, borrow_out=1, overflow=0.
- Start with a=8, b=1, b_in=0 (signed -8 - 1).
  - Expected: diff=7, borrow_out=0, overflow=1.
- Start with a=7, b=15, b_in=0.
  - Expected: diff=8, borrow_out=1, overflow=1.
- Start with a=0, b=0, b_in=1.
  - Expected: diff=15, borrow_out=1, overflow=0.
- Handshake and reset stress:
  - Start a=9, b=2; pulse start again with a=1, b=1 during busy. Expected: one done only, diff=7.
  - Start again and assert rst between clock edges on the 2nd busy cycle. Expected: all outputs 0 immediately and no done afterwards.
  - Start a=4, b=4 after reset. Expected: diff=0, borrow_out=0.
